// File: rtl/ctrl_unit_pipe.sv
// pentaRV decode/control unit: combinational D-stage decode feeding a registered D->E
// control bundle, with optional M-extension decode and a multi-cycle divide hold.
module ctrl_unit_pipe #(
  parameter bit EN_M       = 1'b1,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcodeD,
  input  logic [2:0] funct3D,
  input  logic [6:0] funct7D,
  input  logic       validD,
  input  logic       stallD,
  input  logic       flushE,
  output logic [2:0] immSelD,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       MemtoRegE,
  output logic       PCBranchE,
  output logic [3:0] ALUopE,
  output logic [1:0] SrcASelE,
  output logic [1:0] SrcBSelE,
  output logic [2:0] strCtrlE,
  output logic       MulDivE,
  output logic [2:0] mdOpE,
  output logic       validE,
  output logic       illegalE,
  output logic       busy
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // DIV_CYCLES = 1 would give a zero-width counter; keep one bit that is never loaded non-zero.
  localparam int            CW       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_branch;
    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] str_ctrl;
    logic       mul_div;
    logic [2:0] md_op;
    logic       valid;
    logic       illegal;
  } ctrl_t;

  ctrl_t         dec, ctrl_d, ctrl_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          known, bad, illegal, div_start;

  always_comb begin
    dec          = '0;
    dec.src_a    = 2'b11;
    dec.str_ctrl = funct3D;
    immSelD      = 3'd6;
    known        = 1'b1;
    bad          = 1'b0;
    case (opcodeD)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.src_b      = 2'b01;
        immSelD        = 3'd5;
        bad            = funct3D inside {3'b011, 3'b110, 3'b111};
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.src_b     = 2'b01;
        immSelD       = 3'd2;
        bad           = funct3D > 3'b010;
      end
      OP_ALUI: begin
        dec.reg_write = 1'b1;
        dec.src_b     = 2'b01;
        immSelD       = 3'd0;
        dec.alu_op    = {(funct3D == 3'b101) & funct7D[5], funct3D};
        bad = ((funct3D == 3'b001) && (funct7D != 7'b0000000)) ||
              ((funct3D == 3'b101) && (funct7D != 7'b0000000) && (funct7D != 7'b0100000));
      end
      OP_ALUR: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = {funct7D[5], funct3D};
        if (EN_M && (funct7D == 7'b0000001)) begin
          dec.mul_div = 1'b1;
          dec.md_op   = funct3D;
          dec.alu_op  = 4'b0000;
        end else begin
          bad = !((funct7D == 7'b0000000) ||
                  ((funct7D == 7'b0100000) && (funct3D inside {3'b000, 3'b101})));
        end
      end
      OP_BRANCH: begin
        dec.pc_branch = 1'b1;
        dec.alu_op    = {1'b0, funct3D};
        immSelD       = 3'd3;
        bad           = funct3D inside {3'b010, 3'b011};
      end
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.pc_branch = 1'b1;
        dec.src_a     = 2'b00;
        dec.src_b     = 2'b10;
        immSelD       = 3'd4;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.pc_branch = 1'b1;
        dec.src_a     = 2'b00;
        dec.src_b     = 2'b10;
        immSelD       = 3'd5;
        bad           = funct3D != 3'b000;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.src_a     = 2'b01;
        dec.src_b     = 2'b01;
        immSelD       = 3'd1;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.src_a     = 2'b00;
        dec.src_b     = 2'b01;
        immSelD       = 3'd1;
      end
      default: known = 1'b0;
    endcase
    illegal     = validD & (!known | bad);
    dec.valid   = validD;
    dec.illegal = illegal;
    // Bubbles and illegal instructions must never cause side effects downstream.
    if (!validD || illegal) begin
      dec.reg_write  = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.pc_branch  = 1'b0;
      dec.mul_div    = 1'b0;
    end
  end

  assign div_start = dec.mul_div & funct3D[2];
  assign busy      = (cnt_q != '0);

  // A divide in flight is older than any redirect, so it outranks flush and stall.
  always_comb begin
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - CW'(1);
    end else if (flushE || stallD) begin
      ctrl_d = '0;
    end else begin
      ctrl_d = dec;
      if (div_start) cnt_d = DIV_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RegWriteE = ctrl_q.reg_write;
  assign MemWriteE = ctrl_q.mem_write;
  assign MemtoRegE = ctrl_q.mem_to_reg;
  assign PCBranchE = ctrl_q.pc_branch;
  assign ALUopE    = ctrl_q.alu_op;
  assign SrcASelE  = ctrl_q.src_a;
  assign SrcBSelE  = ctrl_q.src_b;
  assign strCtrlE  = ctrl_q.str_ctrl;
  assign MulDivE   = ctrl_q.mul_div;
  assign mdOpE     = ctrl_q.md_op;
  assign validE    = ctrl_q.valid;
  assign illegalE  = ctrl_q.illegal;

endmodule
